// File: rtl/mem_responder.sv
// Multi-cycle word memory target for a single-memory multi-cycle CPU.
// Fixed-latency read/write service with misaligned/illegal request flagging.
module mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16384,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  error
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_rd;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_error;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_do_access;
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [DATA_WIDTH-1:0] w_a_din;
    logic                  w_a_rd;
    logic                  w_a_wr;
    logic                  w_illegal;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_mem_we;
    logic                  w_unused_bits;

    // With LATENCY=1 the access happens at the acceptance edge,
    // so the live inputs are used; otherwise the latched request.
    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle && (mem_read || mem_write);
    assign w_do_access = (r_state == S_BUSY && r_cnt == 4'd0)
                      || (LATENCY == 1 && w_accept);
    assign w_a_addr    = w_idle ? addr      : r_addr;
    assign w_a_din     = w_idle ? din       : r_din;
    assign w_a_rd      = w_idle ? mem_read  : r_rd;
    assign w_a_wr      = w_idle ? mem_write : r_wr;
    assign w_illegal   = (w_a_addr[1:0] != 2'b00) || (w_a_rd && w_a_wr);
    assign w_idx       = w_a_addr[IDX_W+1:2];
    assign w_mem_we    = reset && w_do_access && w_a_wr && !w_illegal;

    // Upper address bits wrap modulo DEPTH and are intentionally unused.
    assign w_unused_bits = ^{w_a_addr[ADDR_WIDTH-1:IDX_W+2]};

    assign dout      = r_dout;
    assign mem_ready = r_ready;
    assign busy      = r_busy;
    assign error     = r_error;

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_a_din;
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    if (w_accept) begin
                        r_addr <= addr;
                        r_din  <= din;
                        r_rd   <= mem_read;
                        r_wr   <= mem_write;
                        r_busy <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_error <= w_illegal;
                            if (w_illegal) begin
                                r_dout <= '0;
                            end else if (w_a_rd) begin
                                r_dout <= r_mem[w_idx];
                            end
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_error <= w_illegal;
                        if (w_illegal) begin
                            r_dout <= '0;
                        end else if (w_a_rd) begin
                            r_dout <= r_mem[w_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=1)
// driven by directed and random requests against a word-level model.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] di [2];

    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1, busy0, busy1, err0, err1;

    int          n_tests;
    int          n_fail;
    logic [31:0] mdl [int];
    logic [31:0] exp_dout [2];
    int          lat_cfg [2];

    mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(ad[0]), .din(di[0]),
        .dout(dout0), .mem_ready(rdy0),
        .busy(busy0), .error(err0)
    );

    mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(ad[1]), .din(di[1]),
        .dout(dout1), .mem_ready(rdy1),
        .busy(busy1), .error(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dout_of(input int w);
        return (w == 1) ? dout1 : dout0;
    endfunction
    function automatic logic rdy_of(input int w);
        return (w == 1) ? rdy1 : rdy0;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 1) ? busy1 : busy0;
    endfunction
    function automatic logic err_of(input int w);
        return (w == 1) ? err1 : err0;
    endfunction

    // One request; the model decides the expected response from the
    // request alone. With hold=1 the request stays asserted through
    // BUSY and RESP and is dropped in the following IDLE cycle.
    task automatic req(input int w, input bit r, input bit wv,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit hold);
        int          key;
        bit          ill;
        int          nrdy;
        int          nerr;
        int          lat;
        int          exp_lat;
        logic        eobs;
        logic [31:0] dobs;
        key = w * 65536 + int'((a >> 2) & 32'h3FFF);
        ill = (a[1:0] != 2'b00) || (r && wv);
        if (ill) exp_dout[w] = 32'h0;
        else if (wv) mdl[key] = d;
        else exp_dout[w] = mdl.exists(key) ? mdl[key] : 32'h0;
        exp_lat = (lat_cfg[w] == 1) ? 0 : lat_cfg[w];

        @(negedge clk);
        rd[w] = r; wr[w] = wv; ad[w] = a; di[w] = d;
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy_of(w)), 32'd1);
        if (!hold) begin rd[w] = 1'b0; wr[w] = 1'b0; end
        nrdy = 0; nerr = 0; lat = -1; eobs = 1'b0; dobs = '0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (hold && lat >= 0 && k == lat + 1) begin
                rd[w] = 1'b0; wr[w] = 1'b0;
            end
            if (rdy_of(w)) begin
                nrdy++;
                if (lat < 0) begin
                    lat = k; eobs = err_of(w); dobs = dout_of(w);
                end
            end
            if (err_of(w)) nerr++;
        end
        rd[w] = 1'b0; wr[w] = 1'b0;
        check("ready_pulse_count", 32'(nrdy), 32'd1);
        check("ready_latency", 32'(lat), 32'(exp_lat));
        check("error_flag", 32'(eobs), 32'(ill));
        check("error_pulse_count", 32'(nerr), 32'(ill));
        check("dout", dobs, exp_dout[w]);
        check("busy_idle", 32'(busy_of(w)), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;
        int          op;
        bit          seen;
        n_tests = 0; n_fail = 0;
        lat_cfg[0] = 2; lat_cfg[1] = 1;
        exp_dout[0] = 32'h0; exp_dout[1] = 32'h0;

        // Reset held with a request pending.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b1; wr[i] = 1'b0; ad[i] = 32'h10; di[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout0, 32'h0);
        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_error", 32'(err0), 32'd0);
        check("rst_dout_l1", dout1, 32'h0);
        check("rst_ready_l1", 32'(rdy1), 32'd0);
        @(negedge clk);
        rd[0] = 1'b0; rd[1] = 1'b0;
        reset = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            seen |= rdy0 | rdy1 | busy0 | busy1 | err0 | err1;
        end
        check("no_pulse_after_reset", 32'(seen), 32'd0);

        // Write then read.
        req(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        req(0, 1, 0, 32'h0000_0010, 32'h0, 0);
        check("read_back_0x10", dout0, 32'hDEAD_BEEF);

        // Wrap-around modulo DEPTH words.
        req(0, 0, 1, 32'h0001_0004, 32'h1234_5678, 0);
        req(0, 1, 0, 32'h0000_0004, 32'h0, 0);
        check("wrap_read", dout0, 32'h1234_5678);

        // Illegal requests.
        req(0, 1, 0, 32'h0000_0013, 32'h0, 0);
        req(0, 0, 1, 32'h0000_0020, 32'h55AA_55AA, 0);
        req(0, 1, 1, 32'h0000_0020, 32'hFFFF_FFFF, 0);
        req(0, 1, 0, 32'h0000_0020, 32'h0, 0);
        check("both_ops_no_write", dout0, 32'h55AA_55AA);

        // Reset aborting an in-flight write.
        req(0, 0, 1, 32'h0000_0040, 32'h0BAD_C0DE, 0);
        @(negedge clk);
        wr[0] = 1'b1; ad[0] = 32'h40; di[0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        seen |= rdy0 | err0;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen |= rdy0 | err0;
        end
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_dout", dout0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= rdy0 | err0;
        end
        check("abort_no_pulse", 32'(seen), 32'd0);
        exp_dout[0] = 32'h0; exp_dout[1] = 32'h0;
        req(0, 1, 0, 32'h0000_0040, 32'h0, 0);
        check("abort_old_value", dout0, 32'h0BAD_C0DE);

        // Request held through BUSY and RESP is serviced once.
        req(0, 1, 0, 32'h0000_0010, 32'h0, 1);

        // LATENCY=1 instance.
        req(1, 0, 1, 32'h0000_0080, 32'hA5A5_0001, 0);
        req(1, 1, 0, 32'h0000_0080, 32'h0, 0);
        check("l1_read", dout1, 32'hA5A5_0001);
        req(1, 1, 0, 32'h0000_0082, 32'h0, 0);
        req(1, 1, 0, 32'h0000_0080, 32'h0, 1);

        // Random traffic over a few slots with random upper bits.
        for (int s = 0; s < 8; s++) begin
            req(0, 0, 1, 32'h100 + 32'(s * 4), $urandom, 0);
            req(1, 0, 1, 32'h100 + 32'(s * 4), $urandom, 0);
        end
        for (int i = 0; i < 30; i++) begin
            sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            op  = $urandom_range(0, 9);
            a   = ($urandom & 32'hFFFF_0000)
                | (32'h100 + 32'($urandom_range(0, 7) * 4));
            d   = $urandom;
            if (op == 0) req(sel, 1, 1, a, d, 0);
            else if (op == 1) req(sel, 1, 0, a | 32'($urandom_range(1, 3)), d, 0);
            else if (op < 6) req(sel, 0, 1, a, d, 0);
            else req(sel, 1, 0, a, d, op == 9);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
